// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus: steering inputs, I-cache request/response and the
// decode-side buffer handshake. master = fetch sequencer, slave = environment.
interface fetch_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              boot_load;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              icache_req_valid;
  logic [ADDR_W-1:0] icache_req_addr;
  logic              icache_req_ready;
  logic              icache_rsp_valid;
  logic [DATA_W-1:0] icache_rsp_data;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_instr;
  logic              id_ready;
  logic              busy;

  modport master (
    input  boot_load, redirect_valid, redirect_pc,
    input  icache_req_ready, icache_rsp_valid, icache_rsp_data, id_ready,
    output icache_req_valid, icache_req_addr, id_valid, id_pc, id_instr, busy
  );

  modport slave (
    output boot_load, redirect_valid, redirect_pc,
    output icache_req_ready, icache_rsp_valid, icache_rsp_data, id_ready,
    input  icache_req_valid, icache_req_addr, id_valid, id_pc, id_instr, busy
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps at most one I-cache
// request in flight and holds one fetched instruction for decode.
//
// state | meaning
// FETCH | presenting a request at pc (when the buffer can take its result)
// WAIT  | request accepted, response will be buffered
// DRAIN | request accepted but steered away; its response is thrown away
module fetch_seq_ctrl #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0000_1000
) (
  input logic        clk,
  input logic        rst,
  fetch_seq_if.master bus
);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [DATA_W-1:0] buf_instr;

  logic              steer;
  logic [ADDR_W-1:0] target;
  logic              req_valid;
  logic              req_fire;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  // boot_load outranks redirect; either one steers the PC the same way
  assign steer  = bus.boot_load | bus.redirect_valid;
  assign target = bus.boot_load ? BOOT_ADDR : bus.redirect_pc;

  // a request is only offered when its response has somewhere to land
  assign req_valid = !rst && (state == FETCH) && (!buf_valid || bus.id_ready);
  // a handshake coinciding with steering is treated as never accepted
  assign req_fire  = req_valid && bus.icache_req_ready && !steer;

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_addr  = pc;
  assign bus.id_valid         = buf_valid;
  assign bus.id_pc            = buf_pc;
  assign bus.id_instr         = buf_instr;
  assign bus.busy             = (state != FETCH) || buf_valid;

  // sequencer state, fetch PC and the single decode buffer entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= align(BOOT_ADDR);
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      if (buf_valid && bus.id_ready) begin
        buf_valid <= 1'b0;
      end
      if (steer) begin
        pc        <= align(target);
        buf_valid <= 1'b0;
        case (state)
          WAIT:    state <= bus.icache_rsp_valid ? FETCH : DRAIN;
          DRAIN:   state <= bus.icache_rsp_valid ? FETCH : DRAIN;
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (req_fire) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (bus.icache_rsp_valid) begin
              buf_valid <= 1'b1;
              buf_pc    <= pc;
              buf_instr <= bus.icache_rsp_data;
              pc        <= align(pc + ADDR_W'(4));
              state     <= FETCH;
            end
          end
          DRAIN: begin
            if (bus.icache_rsp_valid) begin
              state <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Instruction-fetch sequencer between the next-PC logic and the I-cache port.
- Owns the fetch PC, issues at most one outstanding I-cache request, and buffers one response for decode.
- Handles boot-address reload and backend redirects, including killing an in-flight response.

Parameters:
BOOT_ADDR, 32'h0000_1000, PC after reset and on boot_load
ADDR_W, 32, address width
DATA_W, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
boot_load  in  1  force fetch PC to BOOT_ADDR
redirect_valid  in  1  backend redirect request
redirect_pc  in  ADDR_W  redirect target
icache_req_valid  out  1  request valid
icache_req_addr  out  ADDR_W  request address, low 2 bits always 0
icache_req_ready  in  1  I-cache accepts request
icache_rsp_valid  in  1  response valid (single cycle, never before the cycle after acceptance)
icache_rsp_data  in  DATA_W  fetched instruction
id_valid  out  1  buffered instruction valid
id_pc  out  ADDR_W  PC of buffered instruction
id_instr  out  DATA_W  buffered instruction
id_ready  in  1  decode accepts
busy  out  1  state != FETCH or buffer occupied

Behaviour:
- Reset: one clock, synchronous, active-high on rst.
  - pc = BOOT_ADDR, state = FETCH, buffer empty.
  - id_valid = 0, id_pc = 0, id_instr = 0.
  - icache_req_valid forced 0 while rst is high; busy = 0.
- Address rule:
  - Every PC load (boot, redirect, increment) stores {addr[ADDR_W-1:2], 2'b00}.
  - Increment is aligned pc + 4, mod 2^ADDR_W (0xFFFF_FFFC wraps to 0x0000_0000).
- Buffer: one entry {pc, instr, valid}.
  - Frees on id_valid && id_ready.
  - id_* outputs are driven directly from the buffer registers.
- States:
  - FETCH: icache_req_valid = !buf_valid || id_ready; icache_req_addr = pc.
    - On req_valid && req_ready: go to WAIT.
    - icache_req_addr stays stable while valid && !ready, except when replaced by boot_load or redirect.
  - WAIT: no request.
    - On rsp_valid: buffer <= {pc, rsp_data}, pc <= pc + 4, go to FETCH.
  - DRAIN: no request.
    - On rsp_valid: discard response, go to FETCH.
    - pc already holds the new target.
- Steering priority: rst > boot_load > redirect_valid.
  - Target is BOOT_ADDR for boot_load, redirect_pc for redirect.
  - The same steering applies whether boot_load or redirect fires.
  - In FETCH: pc <= target. Any request handshake in that same cycle is ignored: treated as not accepted, state stays FETCH. The I-cache must tolerate a dropped valid.
  - In WAIT without rsp_valid: pc <= target, go to DRAIN.
  - In WAIT with rsp_valid the same cycle: response discarded, pc <= target, go to FETCH.
  - In DRAIN: pc <= target (latest wins), remain in DRAIN until the response arrives.
  - In all states the buffer is cleared (id_valid = 0 next cycle), even if id_ready was high.
- Latency and throughput:
  - Request to buffered instruction = I-cache latency + 1 cycle.
  - Peak throughput is one instruction per 2 cycles with a 1-cycle I-cache.
- Invariants (bench must assert):
  - Never more than one outstanding request.
  - The buffer is never overwritten while valid.
  - The id_pc sequence is monotonic +4 between redirects.

Test Plan:
- Reset then free-run, 1-cycle I-cache, id_ready=1 -> first req addr 0x1000; id_pc sequence 0x1000, 0x1004, 0x1008, each with matching instr.
- id_ready=0 for 5 cycles after first instr -> id_valid held with id_pc=0x1000; icache_req_valid=0 throughout; next request 0x1004 issued in the cycle id_ready returns.
- redirect_pc=0x2002 while in WAIT, response 3 cycles later -> that response discarded, next req addr 0x2000, next id_pc 0x2000, busy=1 during DRAIN.
- redirect coincident with rsp_valid in WAIT -> response dropped, id_valid stays 0, next req addr = target.
- boot_load and redirect_valid (0x3000) same cycle, from a PC of 0x5000 -> next req addr 0x1000; after boot: id_pc 0x1000, then 0x1004.
- Redirect to 0xFFFF_FFFC, stream two instrs -> id_pc 0xFFFF_FFFC then 0x0000_0000.
- rst asserted while in WAIT -> icache_req_valid=0 and id_valid=0 during rst; the stale response arriving later is ignored; first post-reset req addr 0x1000.
